// File: rtl/hdmi_packet_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hdmi_packet_pkg : shared constants and BCH step for data islands |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hdmi_packet_pkg;

  localparam logic [7:0] BCH_POLY      = 8'h83;
  localparam int         HEADER_BITS   = 24;
  localparam int         SUB_BITS      = 56;
  localparam int         PACKET_PIXELS = 32;

  // One serial step of the BCH remainder for G(x)=1+x^6+x^7+x^8.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic data_bit);
    logic f;
    f = ecc[0] ^ data_bit;
    return (ecc >> 1) ^ (f ? BCH_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bch_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bch_lfsr : BCH parity accumulator, BITS_PER_STEP bits per clock   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bch_lfsr
  import hdmi_packet_pkg::*;
#(
  parameter int BITS_PER_STEP = 1
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     advance,
  input  logic [BITS_PER_STEP-1:0] data,
  output logic [7:0]               ecc
);

  logic [7:0] ecc_q;
  logic [7:0] ecc_d;

  // Clear and advance together start a fresh remainder from zero.
  always_comb begin
    ecc_d = clear ? 8'h00 : ecc_q;
    if (advance) begin
      for (int i = 0; i < BITS_PER_STEP; i++) begin
        ecc_d = bch_step(ecc_d, data[i]);
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      ecc_q <= 8'h00;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc = ecc_q;

endmodule
`default_nettype wire

// File: rtl/packet_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | packet_assembler : serialises one HDMI data-island packet per 32  |
// | pixels with BCH parity. Option: PACKET_ASSEMBLER_STATS_EN.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module packet_assembler
  import hdmi_packet_pkg::*;
(
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          data_island_period,
  input  logic [HEADER_BITS-1:0]        header,
  input  logic [3:0][SUB_BITS-1:0]      sub,
  output logic                          packet_enable,
  output logic [4:0]                    packet_pixel_counter,
  output logic [8:0]                    packet_data
`ifdef PACKET_ASSEMBLER_STATS_EN
  ,
  output logic [15:0]                   packets_sent,
  output logic [7:0]                    packets_aborted
`endif
);

  localparam logic [4:0] C_LAST_PIXEL = 5'(PACKET_PIXELS - 1);

  logic [4:0]                   counter_q, counter_d;
  logic [HEADER_BITS-1:0]       hdr_q;
  logic [3:0][SUB_BITS-1:0]     sub_q;
  logic [8:0]                   data_q, data_d;

  logic                         capture;
  logic                         hdr_phase;
  logic                         sub_phase;
  logic                         lfsr_clear;
  logic [HEADER_BITS-1:0]       hdr_sel;
  logic [3:0][SUB_BITS-1:0]     sub_sel;
  logic [7:0]                   ecc_h;
  logic [7:0]                   ecc_s [4];

  // Pixel 0 reads the live inputs; the snapshot only becomes visible at pixel 1.
  assign capture    = data_island_period && (counter_q == 5'd0);
  assign hdr_sel    = capture ? header : hdr_q;
  assign sub_sel    = capture ? sub : sub_q;
  assign hdr_phase  = counter_q < 5'(HEADER_BITS);
  assign sub_phase  = counter_q < 5'(SUB_BITS / 2);
  assign lfsr_clear = !data_island_period || capture;

  bch_lfsr #(.BITS_PER_STEP(1)) u_bch_hdr (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .clear     (lfsr_clear),
    .advance   (data_island_period && hdr_phase),
    .data      (hdr_sel[counter_q]),
    .ecc       (ecc_h)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub
    bch_lfsr #(.BITS_PER_STEP(2)) u_bch_sub (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .clear     (lfsr_clear),
      .advance   (data_island_period && sub_phase),
      .data      ({sub_sel[k][{counter_q, 1'b1}], sub_sel[k][{counter_q, 1'b0}]}),
      .ecc       (ecc_s[k])
    );
  end

  always_comb begin
    counter_d = 5'd0;
    data_d    = 9'h000;
    if (data_island_period) begin
      counter_d = counter_q + 5'd1;
      data_d[0] = hdr_phase ? hdr_sel[counter_q] : ecc_h[counter_q[2:0]];
      for (int k = 0; k < 4; k++) begin
        data_d[1+k] = sub_phase ? sub_sel[k][{counter_q, 1'b0}]
                                : ecc_s[k][{counter_q[1:0], 1'b0}];
        data_d[5+k] = sub_phase ? sub_sel[k][{counter_q, 1'b1}]
                                : ecc_s[k][{counter_q[1:0], 1'b1}];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter_q <= 5'd0;
      data_q    <= 9'h000;
      hdr_q     <= '0;
      sub_q     <= '0;
    end else begin
      counter_q <= counter_d;
      data_q    <= data_d;
      if (capture) begin
        hdr_q <= header;
        sub_q <= sub;
      end
    end
  end

  assign packet_enable        = data_island_period && (counter_q == C_LAST_PIXEL);
  assign packet_pixel_counter = counter_q;
  assign packet_data          = data_q;

`ifdef PACKET_ASSEMBLER_STATS_EN
  logic [15:0] sent_q;
  logic [7:0]  aborted_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sent_q    <= 16'h0000;
      aborted_q <= 8'h00;
    end else begin
      if (packet_enable) begin
        sent_q <= sent_q + 16'h0001;
      end
      if (!data_island_period && (counter_q != 5'd0) && (aborted_q != 8'hFF)) begin
        aborted_q <= aborted_q + 8'h01;
      end
    end
  end

  assign packets_sent    = sent_q;
  assign packets_aborted = aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_packet_assembler : directed bench for packet_assembler         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_packet_assembler;

  logic              clk_pixel = 1'b0;
  logic              reset;
  logic              data_island_period;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic              packet_enable;
  logic [4:0]        packet_pixel_counter;
  logic [8:0]        packet_data;
`ifdef PACKET_ASSEMBLER_STATS_EN
  logic [15:0]       packets_sent;
  logic [7:0]        packets_aborted;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [32];
  logic [7:0] par;

  always #5 clk_pixel = ~clk_pixel;

  packet_assembler dut (
    .clk_pixel            (clk_pixel),
    .reset                (reset),
    .data_island_period   (data_island_period),
    .header               (header),
    .sub                  (sub),
    .packet_enable        (packet_enable),
    .packet_pixel_counter (packet_pixel_counter),
    .packet_data          (packet_data)
`ifdef PACKET_ASSEMBLER_STATS_EN
    ,
    .packets_sent         (packets_sent),
    .packets_aborted      (packets_aborted)
`endif
  );

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_q[i] = 9'h000;
  endtask

  // Header-only parity in bit 0 at pixels 24..31, LSB first.
  task automatic set_hdr_parity(input logic [7:0] p);
    par = p;
    for (int j = 0; j < 8; j++) exp_q[24+j][0] = par[j];
  endtask

  task automatic run_pkt(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_cnt"}, 32'(packet_pixel_counter), 32'(i));
      step();
      check({tag, "_data"}, 32'(packet_data), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    repeat (3) step();
    check("rst_cnt", 32'(packet_pixel_counter), 32'd0);
    check("rst_data", 32'(packet_data), 32'd0);
    check("rst_en", 32'(packet_enable), 32'd0);
`ifdef PACKET_ASSEMBLER_STATS_EN
    check("rst_sent", 32'(packets_sent), 32'd0);
    check("rst_abort", 32'(packets_aborted), 32'd0);
`endif
    reset = 1'b0;
    step();

    // All-zero packet, enable only at pixel 31
    data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("zero_cnt", 32'(packet_pixel_counter), 32'(i));
      check("zero_en", 32'(packet_enable), (i == 31) ? 32'd1 : 32'd0);
      step();
      check("zero_data", 32'(packet_data), 32'd0);
    end
    data_island_period = 1'b0;
    step();
    check("idle_cnt", 32'(packet_pixel_counter), 32'd0);
    check("idle_en", 32'(packet_enable), 32'd0);

    // Header bit 23 only -> parity 8'h83
    data_island_period = 1'b1;
    header = 24'h800000;
    clear_exp();
    exp_q[23] = 9'h001;
    set_hdr_parity(8'h83);
    run_pkt("hdr23");
    data_island_period = 1'b0;
    header = '0;
    step();

    // sub[2] bit 55 only -> odd lane bit 7
    data_island_period = 1'b1;
    sub[2] = 56'h80000000000000;
    clear_exp();
    exp_q[27] = 9'h080;
    exp_q[28] = 9'h088;
    exp_q[31] = 9'h080;
    run_pkt("sub2");
    data_island_period = 1'b0;
    sub = '0;
    step();

    // Back-to-back: first packet must ignore the change made at pixel 5
    data_island_period = 1'b1;
    header = 24'h400000;
    clear_exp();
    exp_q[22] = 9'h001;
    set_hdr_parity(8'hC2);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        header = 24'h800000;
        sub[0] = {56{1'b1}};
      end
      step();
      check("b2b1_data", 32'(packet_data), 32'(exp_q[i]));
    end
    header = 24'h800000;
    sub = '0;
    clear_exp();
    exp_q[23] = 9'h001;
    set_hdr_parity(8'h83);
    run_pkt("b2b2");
    data_island_period = 1'b0;
    header = '0;
    step();

    // Abort at pixel 17
    data_island_period = 1'b1;
    header = 24'hFFFFFF;
    for (int i = 0; i < 17; i++) begin
      step();
      check("abrt_data", 32'(packet_data), 32'h001);
    end
    check("abrt_cnt17", 32'(packet_pixel_counter), 32'd17);
    data_island_period = 1'b0;
    step();
    check("abrt_cnt0", 32'(packet_pixel_counter), 32'd0);
    check("abrt_low0", 32'(packet_data), 32'd0);
    step();
    check("abrt_low1", 32'(packet_data), 32'd0);
`ifdef PACKET_ASSEMBLER_STATS_EN
    check("abrt_sent", 32'(packets_sent), 32'd5);
    check("abrt_count", 32'(packets_aborted), 32'd1);
`endif
    data_island_period = 1'b1;
    header = 24'h800000;
    clear_exp();
    exp_q[23] = 9'h001;
    set_hdr_parity(8'h83);
    run_pkt("after_abrt");
`ifdef PACKET_ASSEMBLER_STATS_EN
    check("sent6", 32'(packets_sent), 32'd6);
`endif

    // Reset mid-packet at pixel 20 while island stays high
    header = 24'hFFFFFF;
    for (int i = 0; i < 20; i++) step();
    check("mrst_cnt20", 32'(packet_pixel_counter), 32'd20);
    reset = 1'b1;
    step();
    check("mrst_cnt", 32'(packet_pixel_counter), 32'd0);
    check("mrst_data", 32'(packet_data), 32'd0);
    check("mrst_en", 32'(packet_enable), 32'd0);
`ifdef PACKET_ASSEMBLER_STATS_EN
    check("mrst_sent", 32'(packets_sent), 32'd0);
    check("mrst_abort", 32'(packets_aborted), 32'd0);
`endif
    reset = 1'b0;
    header = 24'h800000;
    clear_exp();
    exp_q[23] = 9'h001;
    set_hdr_parity(8'h83);
    run_pkt("after_rst");
`ifdef PACKET_ASSEMBLER_STATS_EN
    check("final_sent", 32'(packets_sent), 32'd1);
    check("final_abort", 32'(packets_aborted), 32'd0);
`endif
    data_island_period = 1'b0;
    step();
    check("end_data", 32'(packet_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
